hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL expose parameter NUM_STAGES, default 3, giving the number of in-flight stages tracked after decode (X, M, W); legal range 2..6.
REQ-002 The block SHALL expose parameter FORWARD_EN, default 1, where 1 means bypass paths exist and 0 means stall on every RAW hazard.
REQ-003 The block SHALL expose parameter MAX_MEM_WAIT, default 15, giving the consecutive mem_busy cycles before timeout is flagged.
REQ-004 The block SHALL have ports clock, in, 1, the sole clock, rising edge.
REQ-005 reset_n, in, 1, asynchronous active-low reset.
REQ-006 d_valid, in, 1, decode holds a valid instruction.
REQ-007 d_rs, in, 5, and d_rs_used, in, 1, source A register and whether it is read.
REQ-008 d_rt, in, 5, and d_rt_used, in, 1, source B register and whether it is read.
REQ-009 d_rwe, in, 1, d_dst, in, 5, and d_is_load, in, 1, the decode-stage write enable, destination and load flag.
REQ-010 x_do_branch, in, 1, a taken branch or jump resolved in X this cycle.
REQ-011 mem_busy, in, 1, data memory not ready.
REQ-012 stall_f, out, 1, hold PC and the FD register.
REQ-013 bubble_dx, out, 1, load a NOP into DX.
REQ-014 flush_fd, out, 1, squash the FD instruction.
REQ-015 hold_all, out, 1, freeze every pipeline register.
REQ-016 fwd_a_sel, out, 2, and fwd_b_sel, out, 2, operand source: 0 regfile, 1 XM, 2 MW.
REQ-017 mem_timeout, out, 1, sticky timeout flag.
REQ-018 stall_cycles, out, 16, saturating count of stalled cycles.

Function
REQ-019 The block SHALL keep a scoreboard of NUM_STAGES entries {valid, dst, is_load}; entry 0 is X and entry NUM_STAGES-1 is W.
REQ-020 On each clock with hold_all=0, entry i SHALL take entry i-1, and entry 0 SHALL take {d_valid&d_rwe&(d_dst!=0)&!stall_f&!flush_fd, d_dst, d_is_load}; otherwise entry 0 SHALL take invalid.
REQ-021 A match SHALL be a valid entry with dst equal to a used source; register 0 never matches.
REQ-022 Entry NUM_STAGES-1 SHALL never cause a stall, because the regfile is write-first.
REQ-023 With FORWARD_EN=0, a match in entries 0..NUM_STAGES-2 SHALL assert stall_f=1 and bubble_dx=1 (combinational), and fwd_*_sel SHALL be 0.
REQ-024 With FORWARD_EN=1, a match in entry 0 with is_load=1 SHALL assert stall_f and bubble_dx (load-use, one cycle).
REQ-025 With FORWARD_EN=1, fwd_x_sel SHALL be 1 on an entry-0 match, else 2 on an entry-1 match, else 0; the youngest match wins. Entries 2 and above SHALL need no forwarding.
REQ-026 x_do_branch=1 with hold_all=0 SHALL assert flush_fd=1 and bubble_dx=1 and SHALL suppress stall_f, so the branch overrides the hazard.
REQ-027 mem_busy=1 SHALL assert hold_all=1 and stall_f=1 combinationally, with bubble_dx=0 and flush_fd=0; the scoreboard holds, and hold_all outranks branch and hazard.
REQ-028 The busy counter SHALL increment while mem_busy=1 and clear when mem_busy=0. Reaching MAX_MEM_WAIT SHALL set mem_timeout, which holds until reset.
REQ-029 stall_cycles SHALL increment on every clock with stall_f=1 and saturate at 0xFFFF.
REQ-030 With d_valid=0, no hazard stall SHALL be raised.

Reset
REQ-031 reset_n=0 SHALL immediately clear all scoreboard entries, the busy counter, mem_timeout and stall_cycles.
REQ-032 While reset_n=0, all outputs SHALL be 0.
REQ-033 Reset in mid-stall SHALL release stall_f in the same cycle.
REQ-034 After reset_n rises, the first posedge SHALL be normal operation.

Structure
REQ-035 A shared package SHALL hold the scoreboard entry typedef, the FWD_REGFILE/FWD_XM/FWD_MW encodings and the register-address width 5.
REQ-036 One sub-module, hazard_scoreboard (the shift register plus match vectors), SHALL be instantiated; the priority and counter logic stays in hazard_ctrl.

Verification
REQ-037 Test 1: FORWARD_EN=0, add r3 then sub r4,r3,r1 next cycle -> stall_f=1 for 2 cycles (X, M), then 0 with fwd sel=0.
REQ-038 Test 2: FORWARD_EN=1, lw r5 then add r6,r5,r5 -> one stall cycle, then fwd_a_sel=fwd_b_sel=2.
REQ-039 Test 3: FORWARD_EN=1, add r7 then or r8,r2,r7 -> no stall, fwd_b_sel=1.
REQ-040 Test 4: load-use hazard coincident with x_do_branch=1 -> flush_fd=1, bubble_dx=1, stall_f=0.
REQ-041 Test 5: mem_busy high for 15 cycles with MAX_MEM_WAIT=15 -> hold_all=1 throughout, mem_timeout=1 after the 15th edge, and it persists after busy drops.
REQ-042 Test 6: writes to r0 followed by readers of r0 -> never stall; reset_n pulsed during a stall -> all outputs 0 immediately and stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and encodings for the hazard controller
package hazard_ctrl_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] FWD_REGFILE = 2'd0;
   localparam logic [1:0] FWD_XM      = 2'd1;
   localparam logic [1:0] FWD_MW      = 2'd2;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] dst;
      logic              is_load;
   } sb_entry_t;

   // Youngest producer wins: X beats M, anything older reads the regfile.
   function automatic logic [1:0] fwd_select(input logic hit_x, input logic hit_m);
      return hit_x ? FWD_XM : (hit_m ? FWD_MW : FWD_REGFILE);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode/branch/memory inputs and pipeline control outputs
interface hazard_ctrl_if;
   import hazard_ctrl_pkg::*;

   logic              d_valid;
   logic [REG_AW-1:0] d_rs;
   logic              d_rs_used;
   logic [REG_AW-1:0] d_rt;
   logic              d_rt_used;
   logic              d_rwe;
   logic [REG_AW-1:0] d_dst;
   logic              d_is_load;
   logic              x_do_branch;
   logic              mem_busy;

   logic              stall_f;
   logic              bubble_dx;
   logic              flush_fd;
   logic              hold_all;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic              mem_timeout;
   logic [15:0]       stall_cycles;

   modport master (
      output d_valid, d_rs, d_rs_used, d_rt, d_rt_used, d_rwe, d_dst, d_is_load,
             x_do_branch, mem_busy,
      input  stall_f, bubble_dx, flush_fd, hold_all, fwd_a_sel, fwd_b_sel,
             mem_timeout, stall_cycles
   );

   modport slave (
      input  d_valid, d_rs, d_rs_used, d_rt, d_rt_used, d_rwe, d_dst, d_is_load,
             x_do_branch, mem_busy,
      output stall_f, bubble_dx, flush_fd, hold_all, fwd_a_sel, fwd_b_sel,
             mem_timeout, stall_cycles
   );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// rtl/hazard_ctrl_scoreboard.sv - in-flight destination shift register and source match vectors
module hazard_scoreboard
   import hazard_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  hold_i,
   input  sb_entry_t             push_i,
   input  logic [REG_AW-1:0]     rs_i,
   input  logic                  rs_used_i,
   input  logic [REG_AW-1:0]     rt_i,
   input  logic                  rt_used_i,
   output logic [NUM_STAGES-1:0] match_a_o,
   output logic [NUM_STAGES-1:0] match_b_o,
   output logic [NUM_STAGES-1:0] load_o
);

   sb_entry_t [NUM_STAGES-1:0] entry_q;

   // Advance one stage per clock unless the whole pipeline is frozen.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         entry_q <= '0;
      end else if (!hold_i) begin
         entry_q <= {entry_q[NUM_STAGES-2:0], push_i};
      end
   end

   // Per-entry source comparison; register 0 is hardwired and never matches.
   always_comb begin
      match_a_o = '0;
      match_b_o = '0;
      load_o    = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         match_a_o[i] = entry_q[i].valid && rs_used_i && (rs_i != '0) && (entry_q[i].dst == rs_i);
         match_b_o[i] = entry_q[i].valid && rt_used_i && (rt_i != '0) && (entry_q[i].dst == rt_i);
         load_o[i]    = entry_q[i].is_load;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard priority, forwarding select and stall counters
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int NUM_STAGES   = 3,
   parameter int FORWARD_EN   = 1,
   parameter int MAX_MEM_WAIT = 15
) (
   input logic          clock,
   input logic          reset_n,
   hazard_ctrl_if.slave bus
);

   localparam logic [NUM_STAGES-1:0] X_MASK   = NUM_STAGES'(1);
   localparam logic [NUM_STAGES-1:0] W_MASK   = X_MASK << (NUM_STAGES - 1);
   localparam logic [15:0]           MAX_WAIT = 16'(MAX_MEM_WAIT);

   logic [NUM_STAGES-1:0] match_a, match_b, entry_load;
   logic [NUM_STAGES-1:0] a_hit, b_hit, any_hit;
   logic                  raw_stall;
   sb_entry_t             push_entry;

   logic [15:0] busy_cnt_q, busy_cnt_d;
   logic        mem_timeout_q, mem_timeout_d;
   logic [15:0] stall_cycles_q, stall_cycles_d;

   hazard_scoreboard #(.NUM_STAGES(NUM_STAGES)) u_scoreboard (
      .clock     (clock),
      .reset_n   (reset_n),
      .hold_i    (bus.hold_all),
      .push_i    (push_entry),
      .rs_i      (bus.d_rs),
      .rs_used_i (bus.d_rs_used),
      .rt_i      (bus.d_rt),
      .rt_used_i (bus.d_rt_used),
      .match_a_o (match_a),
      .match_b_o (match_b),
      .load_o    (entry_load)
   );

   // Hazard detection: W never stalls; with bypass only a load sitting in X does.
   always_comb begin
      a_hit     = bus.d_valid ? match_a : '0;
      b_hit     = bus.d_valid ? match_b : '0;
      any_hit   = a_hit | b_hit;
      raw_stall = (FORWARD_EN != 0) ? |(any_hit & entry_load & X_MASK)
                                    : |(any_hit & ~W_MASK);
   end

   // Control priority: reset, then memory hold, then branch, then RAW hazard.
   always_comb begin
      bus.stall_f   = 1'b0;
      bus.bubble_dx = 1'b0;
      bus.flush_fd  = 1'b0;
      bus.hold_all  = 1'b0;
      if (!reset_n) begin
         bus.stall_f = 1'b0;
      end else if (bus.mem_busy) begin
         bus.hold_all = 1'b1;
         bus.stall_f  = 1'b1;
      end else if (bus.x_do_branch) begin
         bus.flush_fd  = 1'b1;
         bus.bubble_dx = 1'b1;
      end else if (raw_stall) begin
         bus.stall_f   = 1'b1;
         bus.bubble_dx = 1'b1;
      end
      bus.fwd_a_sel = (reset_n && FORWARD_EN != 0) ? fwd_select(a_hit[0], a_hit[1]) : FWD_REGFILE;
      bus.fwd_b_sel = (reset_n && FORWARD_EN != 0) ? fwd_select(b_hit[0], b_hit[1]) : FWD_REGFILE;
      push_entry.valid   = bus.d_valid && bus.d_rwe && (bus.d_dst != '0) && !bus.stall_f && !bus.flush_fd;
      push_entry.dst     = bus.d_dst;
      push_entry.is_load = bus.d_is_load;
   end

   // Next state of the busy run length, sticky timeout and saturating stall count.
   always_comb begin
      busy_cnt_d     = '0;
      mem_timeout_d  = mem_timeout_q;
      stall_cycles_d = stall_cycles_q;
      if (bus.mem_busy) begin
         busy_cnt_d = (busy_cnt_q >= MAX_WAIT) ? busy_cnt_q : busy_cnt_q + 16'd1;
         if (busy_cnt_d >= MAX_WAIT) begin
            mem_timeout_d = 1'b1;
         end
      end
      if (bus.stall_f && stall_cycles_q != 16'hFFFF) begin
         stall_cycles_d = stall_cycles_q + 16'd1;
      end
   end

   // Counter and flag registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_cnt_q     <= '0;
         mem_timeout_q  <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         busy_cnt_q     <= busy_cnt_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign bus.mem_timeout  = mem_timeout_q;
   assign bus.stall_cycles = stall_cycles_q;

endmodule
